// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source for the VGA controller: solid, colour bars, checkerboard and a
// bouncing box, emitted as registered RGB332. Optional 64-px grid overlay under `PAT_GRID_EN`.

module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BAR_W    = 80,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned BOX_SIZE = 32
) (
  input  logic       CLKIN_IN,
  input  logic       RST_IN,
  input  logic [9:0] posX,
  input  logic [9:0] posY,
  input  logic       disp_en,
  input  logic       VS,
  input  logic [1:0] MODE_SEL,
  input  logic [7:0] COLOR,
  output logic [7:0] PIX_DATA,
  output logic [7:0] FRAME_CNT
);

  localparam logic [10:0] BxMax   = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] ByMax   = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] BoxSize = 11'(BOX_SIZE);

  typedef enum logic [1:0] {
    ModeSolid = 2'd0,
    ModeBars  = 2'd1,
    ModeCheck = 2'd2,
    ModeBox   = 2'd3
  } mode_e;

  // Registered state
  logic        vs_q;
  mode_e       mode_q, mode_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [10:0] bx_q, bx_d;
  logic [10:0] by_q, by_d;
  logic        dir_x_q, dir_x_d;  // 1 = moving towards 0
  logic        dir_y_q, dir_y_d;
  logic [7:0]  pix_q, pix_d;

  logic        frame_start;
  logic [10:0] pos_x11;
  logic [10:0] pos_y11;
  logic [2:0]  bar_idx;
  logic [7:0]  bar_color;
  logic        chk_sel;
  logic        in_box;
  logic [7:0]  pat;

  assign frame_start = vs_q & ~VS;
  assign pos_x11     = {1'b0, posX};
  assign pos_y11     = {1'b0, posY};

  // Frame-rate state: mode latch, frame counter and box motion.
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    if (frame_start) begin
      mode_d      = mode_e'(MODE_SEL);
      frame_cnt_d = frame_cnt_q + 8'd1;

      if (!dir_x_q) begin
        if (bx_q == BxMax) begin
          dir_x_d = 1'b1;
          bx_d    = bx_q - 11'd1;
        end else begin
          bx_d = bx_q + 11'd1;
        end
      end else begin
        if (bx_q == 11'd0) begin
          dir_x_d = 1'b0;
          bx_d    = 11'd1;
        end else begin
          bx_d = bx_q - 11'd1;
        end
      end

      if (!dir_y_q) begin
        if (by_q == ByMax) begin
          dir_y_d = 1'b1;
          by_d    = by_q - 11'd1;
        end else begin
          by_d = by_q + 11'd1;
        end
      end else begin
        if (by_q == 11'd0) begin
          dir_y_d = 1'b0;
          by_d    = 11'd1;
        end else begin
          by_d = by_q - 11'd1;
        end
      end
    end
  end

  // posX / BAR_W as a compare chain, saturating at bar 7.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (pos_x11 >= 11'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    unique case (bar_idx)
      3'd0: bar_color = 8'hFF;
      3'd1: bar_color = 8'hFC;
      3'd2: bar_color = 8'h1F;
      3'd3: bar_color = 8'h1C;
      3'd4: bar_color = 8'hE3;
      3'd5: bar_color = 8'hE0;
      3'd6: bar_color = 8'h03;
      3'd7: bar_color = 8'h00;
      default: bar_color = 8'h00;
    endcase
  end

  assign chk_sel = posX[CHK_LOG2] ^ posY[CHK_LOG2];
  assign in_box  = (pos_x11 >= bx_q) && (pos_x11 < bx_q + BoxSize) &&
                   (pos_y11 >= by_q) && (pos_y11 < by_q + BoxSize);

  // Pixel select uses the registered (pre-update) mode and box position.
  always_comb begin
    pat = 8'h00;
    unique case (mode_q)
      ModeSolid: pat = COLOR;
      ModeBars:  pat = bar_color;
      ModeCheck: pat = chk_sel ? ~COLOR : COLOR;
      ModeBox:   pat = in_box ? COLOR : 8'h00;
      default:   pat = 8'h00;
    endcase
`ifdef PAT_GRID_EN
    if ((posX[5:0] == 6'd0) || (posY[5:0] == 6'd0)) begin
      pat = 8'hFF;
    end
`endif
    pix_d = disp_en ? pat : 8'h00;
  end

  always_ff @(posedge CLKIN_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      vs_q        <= 1'b1;
      mode_q      <= ModeSolid;
      frame_cnt_q <= 8'd0;
      bx_q        <= 11'd0;
      by_q        <= 11'd0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      pix_q       <= 8'h00;
    end else begin
      vs_q        <= VS;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      pix_q       <= pix_d;
    end
  end

  assign PIX_DATA  = pix_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule
